fmap_collector: RTL and testbench

Upstream staging buffer for `max_pooling_mult`. It accepts one IEEE-754 fp32 feature-map element per cycle from the convolution engine over a valid/ready stream and can apply ReLU on the way in. It assembles a full WIDTH×HEIGHT×CH map into the flat bus format that `max_pooling_mult` consumes on `multi_input_data`, then presents the frame and holds it until the pooling side acknowledges it.

---
 rtl/fmap_collector.sv | 53 +++++
 tb/tb_fmap_collector.sv | 145 ++++++++++++++
 2 files changed

// File: rtl/fmap_collector.sv
// fmap_collector: stages a WIDTHxHEIGHTxCH fp32 stream (optional ReLU) into a flat bus frame
module fmap_collector #(
  parameter int WIDTH = 46,
  parameter int HEIGHT = 46,
  parameter int CH = 32,
  parameter int DATA_W = 32,
  parameter int RELU_EN = 1,
  localparam int N = WIDTH * HEIGHT * CH,
  localparam int CW = $clog2(N + 1)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [DATA_W-1:0]   in_data,
  input  logic                in_last,
  output logic [DATA_W*N-1:0] multi_output_data,
  output logic                out_valid,
  input  logic                out_ack,
  output logic [CW-1:0]       elem_count,
  output logic                frame_err
);
  typedef enum logic {FILL, FULL} state_t;
  state_t state, state_nx;
  logic accept, at_end;
  logic [DATA_W-1:0] wdata;
  assign accept = in_valid && in_ready;
  assign at_end = elem_count == CW'(N - 1);
  // sign bit alone decides ReLU, so -0 and negative NaN also collapse to zero
  assign wdata = (RELU_EN != 0 && in_data[DATA_W-1]) ? '0 : in_data;
  always_comb begin
    state_nx = state;
    state_nx = state == FILL ? (accept && at_end ? FULL : FILL) : (out_ack ? FILL : FULL);
  end
  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= FILL;
      elem_count <= '0;
      out_valid <= 1'b0;
      in_ready <= 1'b0;
      frame_err <= 1'b0;
      multi_output_data <= '0;
    end else begin
      state <= state_nx;
      out_valid <= state_nx == FULL;
      in_ready <= state_nx == FILL;
      frame_err <= accept && (in_last != at_end);
      if (accept) multi_output_data[elem_count*DATA_W +: DATA_W] <= wdata;
      if (accept) elem_count <= at_end ? CW'(N) : (in_last ? '0 : elem_count + 1'b1);
      else if (state == FULL && out_ack) elem_count <= '0;
    end
  end
endmodule

// File: tb/tb_fmap_collector.sv
// tb_fmap_collector: directed + random frames checked against a slot-array reference model
module tb_fmap_collector;
  localparam int W = 4, H = 4, C = 2, DW = 32, N = W * H * C, CW = $clog2(N + 1);
  logic clk = 0, reset = 0, in_valid = 0, in_last = 0, out_ack = 0;
  logic [DW-1:0] in_data = '0;
  logic in_ready, out_valid, frame_err, in_ready2, out_valid2, frame_err2;
  logic [DW*N-1:0] bus, bus2;
  logic [CW-1:0] elem_count, elem_count2;
  int total = 0, bad = 0;
  logic [DW-1:0] exp_mem [N];
  logic [DW-1:0] exp_raw [N];
  int k = 0;
  bit exp_full = 0, exp_err = 0;

  always #5 clk = ~clk;

  fmap_collector #(.WIDTH(W), .HEIGHT(H), .CH(C), .DATA_W(DW), .RELU_EN(1)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_last(in_last), .multi_output_data(bus), .out_valid(out_valid), .out_ack(out_ack),
    .elem_count(elem_count), .frame_err(frame_err));
  fmap_collector #(.WIDTH(W), .HEIGHT(H), .CH(C), .DATA_W(DW), .RELU_EN(0)) dut_raw (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready2), .in_data(in_data),
    .in_last(in_last), .multi_output_data(bus2), .out_valid(out_valid2), .out_ack(out_ack),
    .elem_count(elem_count2), .frame_err(frame_err2));

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_bus(input string tag);
    for (int i = 0; i < N; i++) begin
      chk($sformatf("%s_relu_w%0d", tag, i), 64'(bus[i*DW +: DW]), 64'(exp_mem[i]));
      chk($sformatf("%s_raw_w%0d", tag, i), 64'(bus2[i*DW +: DW]), 64'(exp_raw[i]));
    end
  endtask

  task automatic chk_ctl(input string tag);
    chk({tag, "_count"}, 64'(elem_count), 64'(k));
    chk({tag, "_valid"}, 64'(out_valid), 64'(exp_full));
    chk({tag, "_ready"}, 64'(in_ready), 64'(!exp_full));
    chk({tag, "_err"}, 64'(frame_err), 64'(exp_err));
    chk({tag, "_raw_count"}, 64'(elem_count2), 64'(k));
    chk({tag, "_raw_err"}, 64'(frame_err2), 64'(exp_err));
  endtask

  task automatic step(input bit v, input logic [DW-1:0] d, input bit l, input bit ack, input string tag);
    in_valid = v; in_data = d; in_last = l; out_ack = ack;
    @(posedge clk); #1;
    in_valid = 0; in_last = 0; out_ack = 0;
    exp_err = 0;
    if (v && !exp_full) begin
      exp_mem[k] = d[DW-1] ? '0 : d;
      exp_raw[k] = d;
      if (k == N - 1) begin exp_full = 1; exp_err = !l; k = N; end
      else if (l) begin exp_err = 1; k = 0; end
      else k++;
    end else if (exp_full && ack) begin
      exp_full = 0; k = 0;
    end
    chk_ctl(tag);
  endtask

  task automatic do_reset(input int cycles);
    reset = 0; in_valid = 0; out_ack = 0;
    repeat (cycles) @(posedge clk);
    #1;
    k = 0; exp_full = 0; exp_err = 0;
    for (int i = 0; i < N; i++) begin exp_mem[i] = '0; exp_raw[i] = '0; end
    chk("rst_ready", 64'(in_ready), 64'd0);
    chk("rst_valid", 64'(out_valid), 64'd0);
    chk("rst_count", 64'(elem_count), 64'd0);
    chk("rst_err", 64'(frame_err), 64'd0);
    chk("rst_bus", 64'(|bus), 64'd0);
    chk("rst_bus_raw", 64'(|bus2), 64'd0);
    reset = 1;
    @(posedge clk); #1;
    chk("post_rst_ready", 64'(in_ready), 64'd1);
    chk("post_rst_count", 64'(elem_count), 64'd0);
  endtask

  task automatic frame(input int mode, input bit with_last, input string tag);
    logic [DW-1:0] pat [4];
    logic [DW-1:0] d;
    pat[0] = 32'h0C000000; pat[1] = 32'h8C000000; pat[2] = 32'h0A000000; pat[3] = 32'h80000000;
    for (int i = 0; i < N; i++) begin
      d = mode == 0 ? 32'h0C000000 : mode == 1 ? pat[i % 4] : mode == 2 ? DW'(i) :
          mode == 3 ? 32'h0D000000 : $urandom;
      step(1, d, with_last && i == N - 1, 0, tag);
    end
  endtask

  task automatic ack_frame(input string tag);
    step(0, '0, 0, 1, {tag, "_ack"});
  endtask

  initial begin
    do_reset(2);
    frame(0, 1, "basic");
    chk("basic_full_valid", 64'(out_valid), 64'd1);
    chk("basic_full_count", 64'(elem_count), 64'(N));
    chk_bus("basic");
    for (int i = 0; i < 5; i++) step(1, $urandom, $urandom_range(0, 1), 0, "bp_hold");
    chk_bus("bp");
    ack_frame("bp");
    frame(1, 1, "relu");
    chk_bus("relu");
    ack_frame("relu");
    for (int i = 0; i < N; i++) step(1, DW'(i), i == N - 1, i % 7 == 3, "order");
    chk("order_w17", 64'(bus[17*DW +: DW]), 64'd17);
    chk_bus("order");
    ack_frame("order");
    for (int i = 0; i < 10; i++) step(1, $urandom, i == 9, 0, "err_early");
    chk("err_early_cnt0", 64'(elem_count), 64'd0);
    step(0, '0, 0, 0, "err_early_clear");
    frame(4, 1, "after_err");
    chk_bus("after_err");
    ack_frame("after_err");
    frame(4, 0, "nolast");
    chk("nolast_valid", 64'(out_valid), 64'd1);
    chk_bus("nolast");
    ack_frame("nolast");
    for (int i = 0; i < 20; i++) step(1, $urandom, 0, 0, "mid");
    do_reset(1);
    frame(3, 1, "post_rst");
    chk_bus("post_rst");
    ack_frame("post_rst");
    for (int f = 0; f < 3; f++) begin
      int sent = 0;
      while (!exp_full && sent < 4 * N) begin
        step($urandom_range(0, 3) != 0, $urandom, 0, $urandom_range(0, 1), "rnd");
        sent++;
      end
      chk("rnd_done", 64'(exp_full), 64'd1);
      chk_bus("rnd");
      repeat ($urandom_range(1, 3)) step(1, $urandom, 1, 0, "rnd_hold");
      ack_frame("rnd");
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
